// File: rtl/mc_control_fsm.sv
// Multicycle control unit: instruction-sequencing FSM driving datapath enables and mux selects.
// Optional illegal-opcode trap state enabled by defining CTRL_ILLEGAL_TRAP_EN.
module mc_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       irWrite,
  output logic       memRead,
  output logic       memWrite,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic [1:0] regDst,
  output logic [1:0] memToReg,
  output logic [3:0] stateOut,
  output logic       illegalOp
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
`ifdef CTRL_ILLEGAL_TRAP_EN
    S_JUMP     = 4'd12,
    S_TRAP     = 4'd13
`else
    S_JUMP     = 4'd12
`endif
  } state_t;

  state_t     state_reg;
  state_t     state_next;
  logic [3:0] op_reg;

  // The branch decision is taken in the datapath through pcWriteCond.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_RESET;
      op_reg    <= 4'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_DECODE) begin
        op_reg <= opcode;
      end
    end
  end

  assign stateOut = state_reg;

  always_comb begin
    state_next  = S_RESET;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    irWrite     = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'd0;
    aluOp       = 2'd0;
    pcSource    = 2'd0;
    regDst      = 2'd0;
    memToReg    = 2'd0;
    illegalOp   = 1'b0;

    case (state_reg)
      S_RESET: state_next = S_FETCH;
      S_FETCH: begin
        memRead    = 1'b1;
        aluSrcB    = 2'd1;
        irWrite    = memReady;
        pcWrite    = memReady;
        state_next = memReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        aluSrcB = 2'd3;
        case (opcode)
          4'd0:       state_next = S_EXEC_R;
          4'd1:       state_next = S_EXEC_I;
          4'd2, 4'd3: state_next = S_MEM_ADDR;
          4'd4:       state_next = S_BRANCH;
          4'd5:       state_next = S_JUMP;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:    state_next = S_TRAP;
`else
          default:    state_next = S_FETCH;
`endif
        endcase
      end
      S_EXEC_R: begin
        aluSrcA    = 1'b1;
        aluSrcB    = 2'd0;
        aluOp      = 2'd2;
        state_next = S_WB_R;
      end
      S_WB_R: begin
        regWrite   = 1'b1;
        regDst     = 2'd1;
        state_next = S_FETCH;
      end
      S_EXEC_I: begin
        aluSrcA    = 1'b1;
        aluSrcB    = 2'd2;
        state_next = S_WB_I;
      end
      S_WB_I: begin
        regWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_ADDR: begin
        aluSrcA    = 1'b1;
        aluSrcB    = 2'd2;
        // Load/store split uses the opcode captured in DECODE, not the live IR field.
        state_next = (op_reg == 4'd3) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        memRead    = 1'b1;
        state_next = memReady ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        regWrite   = 1'b1;
        memToReg   = 2'd1;
        state_next = S_FETCH;
      end
      S_MEM_WR: begin
        memWrite   = 1'b1;
        state_next = memReady ? S_FETCH : S_MEM_WR;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'd1;
        pcWriteCond = 1'b1;
        pcSource    = 2'd1;
        state_next  = S_FETCH;
      end
      S_JUMP: begin
        pcWrite    = 1'b1;
        pcSource   = 2'd2;
        state_next = S_FETCH;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegalOp  = 1'b1;
        state_next = S_TRAP;
      end
`endif
      default: state_next = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: expected state codes are queued per scenario and
// popped each cycle; scenario-specific outputs are checked inline.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       zero;
  logic       memReady;
  logic       pcWrite, pcWriteCond, irWrite, memRead, memWrite, regWrite, aluSrcA;
  logic [1:0] aluSrcB, aluOp, pcSource, regDst, memToReg;
  logic [3:0] stateOut;
  logic       illegalOp;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q [$];

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .irWrite(irWrite), .memRead(memRead),
    .memWrite(memWrite), .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .aluOp(aluOp), .pcSource(pcSource), .regDst(regDst), .memToReg(memToReg),
    .stateOut(stateOut), .illegalOp(illegalOp)
  );

  always #5 clk = ~clk;

  wire [17:0] all_out = {pcWrite, pcWriteCond, irWrite, memRead, memWrite, regWrite, aluSrcA,
                         aluSrcB, aluOp, pcSource, regDst, memToReg, illegalOp};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [3:0] seq [$]);
    foreach (seq[k]) exp_q.push_back(seq[k]);
  endtask

  // Scoreboard consumer: compares current state with the next queued expectation.
  task automatic sb_step(input string tag);
    logic [3:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, stateOut=%0d", tag, stateOut);
    end else begin
      e = exp_q.pop_front();
      if (stateOut !== e) begin
        bad++;
        $display("FAIL %s: stateOut=%0d expected=%0d", tag, stateOut, e);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; memReady = 1'b1; opcode = 4'd0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    total++;
    if (all_out !== 18'd0 || stateOut !== 4'd0) begin
      bad++;
      $display("FAIL reset_outputs: outs=%h state=%0d expected 0/0", all_out, stateOut);
    end
    @(posedge clk); #1; reset = 1'b0;
    push_seq('{4'd0});
    sb_step("reset_state");
    tick();
    push_seq('{4'd1});
    sb_step("reset_fetch");
    total++;
    if (irWrite !== 1'b1 || pcWrite !== 1'b1 || aluSrcB !== 2'd1 || memRead !== 1'b1) begin
      bad++;
      $display("FAIL fetch_outputs: ir=%b pc=%b srcB=%0d mr=%b expected 1,1,1,1",
               irWrite, pcWrite, aluSrcB, memRead);
    end
  endtask

  task automatic test_rtype();
    opcode = 4'd0; memReady = 1'b1;
    push_seq('{4'd1, 4'd2, 4'd3, 4'd4});
    for (int i = 0; i < 4; i++) begin
      sb_step("rtype_seq");
      if (i == 2) begin
        total++;
        if (aluSrcB !== 2'd0 || aluOp !== 2'd2 || aluSrcA !== 1'b1) begin
          bad++;
          $display("FAIL rtype_exec: srcB=%0d op=%0d srcA=%b expected 0,2,1", aluSrcB, aluOp, aluSrcA);
        end
      end
      if (i == 3) begin
        total++;
        if (regWrite !== 1'b1 || regDst !== 2'd1 || memToReg !== 2'd0) begin
          bad++;
          $display("FAIL rtype_wb: rw=%b dst=%0d m2r=%0d expected 1,1,0", regWrite, regDst, memToReg);
        end
      end
      tick();
    end
  endtask

  task automatic test_lw_wait();
    opcode = 4'd2;
    push_seq('{4'd1, 4'd2, 4'd7, 4'd8, 4'd8, 4'd8, 4'd8, 4'd9});
    for (int i = 0; i < 8; i++) begin
      sb_step("lw_seq");
      if (i == 4) begin
        total++;
        if (memRead !== 1'b1 || irWrite !== 1'b0 || pcWrite !== 1'b0) begin
          bad++;
          $display("FAIL lw_memrd: mr=%b ir=%b pc=%b expected 1,0,0", memRead, irWrite, pcWrite);
        end
      end
      if (i == 7) begin
        total++;
        if (memToReg !== 2'd1 || regWrite !== 1'b1 || regDst !== 2'd0) begin
          bad++;
          $display("FAIL lw_wb: m2r=%0d rw=%b dst=%0d expected 1,1,0", memToReg, regWrite, regDst);
        end
      end
      memReady = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
      tick();
    end
  endtask

  task automatic test_sw_branch_jump();
    int wr_cnt;
    wr_cnt = 0;
    opcode = 4'd3; memReady = 1'b1;
    push_seq('{4'd1, 4'd2, 4'd7, 4'd10});
    for (int i = 0; i < 4; i++) begin
      sb_step("sw_seq");
      if (memWrite === 1'b1) wr_cnt++;
      if (i == 2) begin
        total++;
        if (aluSrcB !== 2'd2 || aluSrcA !== 1'b1) begin
          bad++;
          $display("FAIL sw_addr: srcB=%0d srcA=%b expected 2,1", aluSrcB, aluSrcA);
        end
      end
      tick();
    end
    total++;
    if (wr_cnt !== 1) begin
      bad++;
      $display("FAIL sw_memwrite_cycles: got=%0d expected=1", wr_cnt);
    end

    opcode = 4'd4;
    push_seq('{4'd1, 4'd2, 4'd11});
    for (int i = 0; i < 3; i++) begin
      sb_step("beq_seq");
      if (i == 2) begin
        total++;
        if (pcWriteCond !== 1'b1 || pcSource !== 2'd1 || aluOp !== 2'd1 || pcWrite !== 1'b0) begin
          bad++;
          $display("FAIL beq_outputs: pwc=%b psrc=%0d op=%0d pw=%b expected 1,1,1,0",
                   pcWriteCond, pcSource, aluOp, pcWrite);
        end
      end
      tick();
    end

    opcode = 4'd5;
    push_seq('{4'd1, 4'd2, 4'd12});
    for (int i = 0; i < 3; i++) begin
      sb_step("jump_seq");
      if (i == 2) begin
        total++;
        if (pcWrite !== 1'b1 || pcSource !== 2'd2) begin
          bad++;
          $display("FAIL jump_outputs: pw=%b psrc=%0d expected 1,2", pcWrite, pcSource);
        end
      end
      tick();
    end
  endtask

  task automatic test_fetch_wait_addi();
    opcode = 4'd1;
    push_seq('{4'd1, 4'd1, 4'd1, 4'd2, 4'd5, 4'd6});
    for (int i = 0; i < 6; i++) begin
      memReady = (i < 2) ? 1'b0 : 1'b1;
      #1;
      sb_step("addi_seq");
      if (i < 2) begin
        total++;
        if (memRead !== 1'b1 || irWrite !== 1'b0 || pcWrite !== 1'b0) begin
          bad++;
          $display("FAIL fetch_wait: mr=%b ir=%b pc=%b expected 1,0,0", memRead, irWrite, pcWrite);
        end
      end
      if (i == 3) begin
        total++;
        if (aluSrcB !== 2'd3 || aluSrcA !== 1'b0 || aluOp !== 2'd0) begin
          bad++;
          $display("FAIL decode_outputs: srcB=%0d srcA=%b op=%0d expected 3,0,0", aluSrcB, aluSrcA, aluOp);
        end
      end
      if (i == 5) begin
        total++;
        if (regWrite !== 1'b1 || regDst !== 2'd0 || memToReg !== 2'd0) begin
          bad++;
          $display("FAIL addi_wb: rw=%b dst=%0d m2r=%0d expected 1,0,0", regWrite, regDst, memToReg);
        end
      end
      tick();
    end
  endtask

  task automatic test_opcode_stability();
    opcode = 4'd2; memReady = 1'b1;
    push_seq('{4'd1, 4'd2, 4'd7, 4'd8, 4'd9});
    for (int i = 0; i < 5; i++) begin
      sb_step("opcode_stable_seq");
      if (i == 2) opcode = 4'd3;
      tick();
    end
  endtask

  task automatic test_illegal();
    opcode = 4'd9; memReady = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
    push_seq('{4'd1, 4'd2});
    for (int i = 0; i < 2; i++) begin
      sb_step("trap_entry");
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      push_seq('{4'd13});
      sb_step("trap_hold");
      total++;
      if (illegalOp !== 1'b1 || pcWrite !== 1'b0 || memRead !== 1'b0 || regWrite !== 1'b0) begin
        bad++;
        $display("FAIL trap_outputs: ill=%b pw=%b mr=%b rw=%b expected 1,0,0,0",
                 illegalOp, pcWrite, memRead, regWrite);
      end
      tick();
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (stateOut !== 4'd0 || illegalOp !== 1'b0) begin
      bad++;
      $display("FAIL trap_reset: state=%0d ill=%b expected 0,0", stateOut, illegalOp);
    end
    @(posedge clk); #1; reset = 1'b0;
    tick();
`else
    push_seq('{4'd1, 4'd2});
    for (int i = 0; i < 2; i++) begin
      sb_step("illegal_nop_seq");
      total++;
      if (illegalOp !== 1'b0) begin
        bad++;
        $display("FAIL illegal_flag: ill=%b expected 0", illegalOp);
      end
      tick();
    end
`endif
  endtask

  task automatic test_midwait_reset();
    opcode = 4'd2;
    push_seq('{4'd1, 4'd2, 4'd7, 4'd8});
    for (int i = 0; i < 4; i++) begin
      sb_step("midwait_seq");
      memReady = (i == 3) ? 1'b0 : 1'b1;
      tick();
    end
    total++;
    if (stateOut !== 4'd8 || memRead !== 1'b1) begin
      bad++;
      $display("FAIL midwait_hold: state=%0d mr=%b expected 8,1", stateOut, memRead);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (all_out !== 18'd0 || stateOut !== 4'd0) begin
      bad++;
      $display("FAIL midwait_async_reset: outs=%h state=%0d expected 0/0", all_out, stateOut);
    end
    @(posedge clk); #1; reset = 1'b0; memReady = 1'b1;
    push_seq('{4'd0});
    sb_step("post_reset_state");
    tick();
    push_seq('{4'd1});
    sb_step("post_reset_fetch");
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_branch_jump();
    test_fetch_wait_addi();
    test_opcode_stability();
    test_illegal();
    push_seq('{4'd1});
    sb_step("back_to_fetch");
    test_midwait_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
